// File: rtl/wb_write_queue.sv
// Writeback queue: arbitrates int/FP results into a DEPTH-entry FIFO and drains one register file write per cycle. Optional macro: WB_BYPASS_EN.
// Latency: accept at edge N reaches regWrite after edge N+1 (after edge N with WB_BYPASS_EN and an empty, unheld queue).
// Backpressure: int_ready/fp_ready drop when the FIFO is full with no same-cycle pop; rf_hold stalls the drain only.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_valid,
  output logic              int_ready,
  input  logic [ADDR_W-1:0] int_reg,
  input  logic [DATA_W-1:0] int_data,
  input  logic              fp_valid,
  output logic              fp_ready,
  input  logic [ADDR_W-1:0] fp_reg,
  input  logic [DATA_W-1:0] fp_data,
  input  logic              rf_hold,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  output logic              float,
  input  logic [ADDR_W-1:0] chk_reg,
  input  logic              chk_float,
  output logic              chk_pending,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic              isFloat;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  wbEntry_t         mem [DEPTH];
  wbEntry_t         accEntry;
  wbEntry_t         head;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] idx;
  logic             rrFavInt;
  logic             pop;
  logic             space;
  logic             intWin;
  logic             fpWin;
  logic             accept;
  logic             enq;
  logic             push;
  logic             bypass;
  logic             hit;

  assign pop   = (count != '0) && !rf_hold;
  // A full queue still takes a new entry when the head leaves in the same cycle.
  assign space = (count < CNT_W'(DEPTH)) || pop;
  assign head  = mem[rdPtr];

  // Round-robin grant: one accept per cycle, the producer not served last wins a tie.
  always_comb begin
    intWin = !reset && space && int_valid && (!fp_valid || rrFavInt);
    fpWin  = !reset && space && fp_valid  && (!int_valid || !rrFavInt);
  end

  assign int_ready = intWin;
  assign fp_ready  = fpWin;
  assign accept    = intWin || fpWin;

  // Select the accepted entry; integer register 0 is acknowledged but dropped.
  always_comb begin
    accEntry.isFloat = fpWin;
    accEntry.addr    = intWin ? int_reg  : fp_reg;
    accEntry.data    = intWin ? int_data : fp_data;
    enq              = accept && !(intWin && (int_reg == '0));
`ifdef WB_BYPASS_EN
    bypass           = (count == '0) && !rf_hold && accept && (accEntry.addr != '0);
`else
    bypass           = 1'b0;
`endif
    push             = enq && !bypass;
  end

  // FIFO storage; contents are only meaningful between rdPtr and rdPtr+count.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= accEntry;
  end

  // Pointers, occupancy and round-robin state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      rrFavInt <= 1'b1;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (accept) rrFavInt <= fpWin;
    end
  end

  // Registered write port: regWrite pulses per drained entry, address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      float     <= 1'b0;
    end else if (bypass) begin
      regWrite  <= 1'b1;
      writeReg  <= accEntry.addr;
      writeData <= accEntry.data;
      float     <= accEntry.isFloat;
    end else if (pop) begin
      regWrite  <= 1'b1;
      writeReg  <= head.addr;
      writeData <= head.data;
      float     <= head.isFloat;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  // Hazard lookup over occupied entries and the live output stage; int r0 never hazards.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[idx].addr == chk_reg) && (mem[idx].isFloat == chk_float))
        hit = 1'b1;
    end
    if (regWrite && (writeReg == chk_reg) && (float == chk_float)) hit = 1'b1;
    if ((chk_reg == '0) && !chk_float) hit = 1'b0;
  end

  assign chk_pending = hit;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue (default build): grants, ordering, hold/full, r0 handling, lookup, reset.
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              int_valid, int_ready;
  logic [ADDR_W-1:0] int_reg;
  logic [DATA_W-1:0] int_data;
  logic              fp_valid, fp_ready;
  logic [ADDR_W-1:0] fp_reg;
  logic [DATA_W-1:0] fp_data;
  logic              rf_hold;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic              flt;
  logic [ADDR_W-1:0] chk_reg;
  logic              chk_float;
  logic              chk_pending;
  logic [CNT_W-1:0]  count;

  int nChecks = 0;
  int nPass   = 0;
  logic [38:0] outQ[$];
  logic [38:0] expQ[$];

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .int_valid(int_valid), .int_ready(int_ready), .int_reg(int_reg), .int_data(int_data),
    .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_reg(fp_reg), .fp_data(fp_data),
    .rf_hold(rf_hold),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite), .float(flt),
    .chk_reg(chk_reg), .chk_float(chk_float), .chk_pending(chk_pending),
    .count(count)
  );

  always #5 clk = ~clk;

  // Record every register file write as {float, reg, data}.
  always @(posedge clk) begin
    #1;
    if (regWrite) outQ.push_back({flt, writeReg, writeData});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] ent(input bit f, input int r, input int d);
    logic [31:0] rv;
    logic [31:0] dv;
    rv = r;
    dv = d;
    return {f, rv[5:0], dv};
  endfunction

  task automatic checkOrder(input string tag);
    check({tag, "_len"}, outQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      if (i < outQ.size()) check($sformatf("%s_%0d", tag, i), outQ[i], expQ[i]);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int  iReg, fReg, r;
    bit  iRdy, fRdy;
    reset = 1'b1; int_valid = 0; int_reg = 0; int_data = 0;
    fp_valid = 0; fp_reg = 0; fp_data = 0; rf_hold = 0; chk_reg = 0; chk_float = 0;

    // Reset state; readys stay low during reset even with valid present.
    repeat (2) tick();
    int_valid = 1; int_reg = 3; fp_valid = 1; fp_reg = 3;
    #1;
    check("rst_int_ready", int_ready, 0);
    check("rst_fp_ready", fp_ready, 0);
    tick();
    int_valid = 0; fp_valid = 0;
    check("rst_count", count, 0);
    check("rst_regWrite", regWrite, 0);
    check("rst_writeReg", writeReg, 0);
    check("rst_writeData", writeData, 0);
    check("rst_float", flt, 0);
    reset = 1'b0;
    tick();

    // Single int write: accepted at edge N, visible after edge N+1.
    int_valid = 1; int_reg = 5; int_data = 32'hDEADBEEF;
    #1;
    check("single_ready", int_ready, 1);
    tick();
    int_valid = 0;
    check("single_N_regWrite", regWrite, 0);
    check("single_N_count", count, 1);
    tick();
    check("single_regWrite", regWrite, 1);
    check("single_writeReg", writeReg, 5);
    check("single_writeData", writeData, 32'hDEADBEEF);
    check("single_float", flt, 0);
    check("single_count", count, 0);
    tick();
    check("single_pulse_end", regWrite, 0);
    check("single_hold_reg", writeReg, 5);

    // Contention: both valid, grants alternate starting with int after reset.
    doReset();
    outQ.delete(); expQ.delete();
    iReg = 1; fReg = 1;
    for (int c = 0; c < 8; c++) begin
      int_valid = (iReg <= 4); int_reg = iReg[5:0]; int_data = 32'h1000 + iReg;
      fp_valid  = (fReg <= 4); fp_reg  = fReg[5:0]; fp_data  = 32'h2000 + fReg;
      #1;
      iRdy = int_ready; fRdy = fp_ready;
      check($sformatf("rr_int_%0d", c), iRdy, (c % 2) == 0);
      check($sformatf("rr_fp_%0d", c), fRdy, (c % 2) == 1);
      tick();
      if (iRdy) iReg++;
      if (fRdy) fReg++;
    end
    int_valid = 0; fp_valid = 0;
    repeat (4) tick();
    for (int k = 1; k <= 4; k++) begin
      expQ.push_back(ent(0, k, 32'h1000 + k));
      expQ.push_back(ent(1, k, 32'h2000 + k));
    end
    checkOrder("rr_order");

    // Fill under hold, then release: full-with-pop still accepts.
    outQ.delete(); expQ.delete();
    rf_hold = 1; r = 1;
    for (int c = 0; c < 6; c++) begin
      int_valid = 1; int_reg = r[5:0]; int_data = 32'h3000 + r;
      #1;
      iRdy = int_ready;
      check($sformatf("fill_ready_%0d", c), iRdy, c < 4);
      tick();
      if (iRdy) r++;
    end
    check("fill_count", count, 4);
    check("fill_no_write", regWrite, 0);
    rf_hold = 0;
    #1;
    check("fullpop_ready", int_ready, 1);
    tick();
    check("fullpop_count", count, 4);
    r++;
    int_reg = r[5:0]; int_data = 32'h3000 + r;
    #1;
    check("fill_ready_6", int_ready, 1);
    tick();
    int_valid = 0;
    repeat (6) tick();
    for (int k = 1; k <= 6; k++) expQ.push_back(ent(0, k, 32'h3000 + k));
    checkOrder("fill_order");

    // Register 0: int write dropped, fp write kept.
    outQ.delete(); expQ.delete();
    int_valid = 1; int_reg = 0; int_data = 32'h55;
    #1;
    check("r0_int_ready", int_ready, 1);
    tick();
    int_valid = 0;
    check("r0_int_count", count, 0);
    repeat (3) tick();
    check("r0_int_nowrite", outQ.size(), 0);
    fp_valid = 1; fp_reg = 0; fp_data = 32'h66;
    #1;
    check("r0_fp_ready", fp_ready, 1);
    tick();
    fp_valid = 0;
    repeat (3) tick();
    expQ.push_back(ent(1, 0, 32'h66));
    checkOrder("r0_fp");

    // Pending lookup: queued fp r7, then output stage, then clear.
    rf_hold = 1;
    fp_valid = 1; fp_reg = 7; fp_data = 32'h77;
    #1;
    tick();
    fp_valid = 0;
    chk_reg = 7; chk_float = 1;
    #1;
    check("pend_fifo_hit", chk_pending, 1);
    chk_float = 0;
    #1;
    check("pend_bank_miss", chk_pending, 0);
    chk_reg = 0;
    #1;
    check("pend_r0_int", chk_pending, 0);
    chk_reg = 7; chk_float = 1;
    rf_hold = 0;
    tick();
    check("pend_out_stage", chk_pending, 1);
    tick();
    check("pend_clear", chk_pending, 0);

    // Reset mid-operation discards queued entries.
    outQ.delete();
    rf_hold = 1;
    for (int k = 10; k < 13; k++) begin
      int_valid = 1; int_reg = k[5:0]; int_data = 32'h4000 + k;
      tick();
    end
    int_valid = 0;
    check("mid_count", count, 3);
    chk_reg = 11; chk_float = 0;
    #1;
    check("mid_pending", chk_pending, 1);
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_count", count, 0);
    check("mid_rst_regWrite", regWrite, 0);
    check("mid_rst_pending", chk_pending, 0);
    rf_hold = 0;
    repeat (5) tick();
    check("mid_no_writes", outQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
